// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute/write-back stage: word sizes, opcodes,
// FSM state encoding and the multiplier iteration count.
package alu_exec_unit_pkg;

    localparam int WIDTH     = 16;
    localparam int ADDR_W    = 3;
    localparam int MUL_ITERS = 16;
    localparam int MUL_CNT_W = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Opcodes 9..15 are undefined and must not touch the register file.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_LDI);
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul16_seq.sv
// Sequential 16x16 shift-add multiplier, low 16 bits of the product.
// One multiplier bit is consumed per cycle; 'done' is high during the last
// iteration and 'product' then already includes that final partial product.
module mul16_seq
    import alu_exec_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0]     acc_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [MUL_CNT_W-1:0] cnt_reg;
    logic                 busy_reg;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     acc_next;

    // Partial product: the shifted multiplicand gated by the current multiplier bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign acc_next = acc_reg + addend;
    assign product  = acc_next;
    assign done     = busy_reg && (cnt_reg == MUL_CNT_W'(MUL_ITERS - 1));

    // Iteration state: load on start, then shift/accumulate until the last bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            acc_reg    <= '0;
            mcand_reg  <= a;
            mplier_reg <= b;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= {mcand_reg[WIDTH-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute/write-back stage looped around the 8x16 register file.
// One instruction in flight: IDLE -> READ -> EXEC -> WRITE -> IDLE.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    input  logic [WIDTH-1:0]  imm,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [WIDTH-1:0]  rf_a,
    input  logic [WIDTH-1:0]  rf_b,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  d_in,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c
);

    state_t            state_reg, state_next;
    logic [3:0]        op_reg;
    logic [ADDR_W-1:0] src_a_reg, src_b_reg, dst_reg;
    logic [WIDTH-1:0]  imm_reg, opa_reg, opb_reg, result_reg;
    logic              flag_z_reg, flag_n_reg, flag_c_reg;

    logic [WIDTH:0]    wide;
    logic [WIDTH-1:0]  alu_result, exec_result;
    logic              alu_carry, exec_carry, exec_done;
    logic              mul_start, mul_done;
    logic [WIDTH-1:0]  mul_product;

    mul16_seq u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (rf_a),
        .b       (rf_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register; reset abandons whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; illegal ops skip WRITE, MUL waits for the multiplier.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (instr_valid) state_next = ST_READ;
            ST_READ:  state_next = ST_EXEC;
            ST_EXEC: begin
                if (!op_is_legal(op_reg)) state_next = ST_IDLE;
                else if (exec_done)       state_next = ST_WRITE;
            end
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state (plus reset gating on ready).
    always_comb begin
        instr_ready = (state_reg == ST_IDLE) && reset;
        wr          = (state_reg == ST_WRITE);
        mul_start   = (state_reg == ST_READ) && (op_reg == OP_MUL);
    end

    assign rd_addr_a = src_a_reg;
    assign rd_addr_b = src_b_reg;
    assign wr_addr   = dst_reg;
    assign d_in      = result_reg;
    assign flag_z    = flag_z_reg;
    assign flag_n    = flag_n_reg;
    assign flag_c    = flag_c_reg;

    // Single-cycle ALU; the 17-bit intermediate carries carry-out / borrow.
    always_comb begin
        wide       = '0;
        alu_result = '0;
        alu_carry  = 1'b0;
        case (op_reg)
            OP_ADD: begin
                wide       = {1'b0, opa_reg} + {1'b0, opb_reg};
                alu_result = wide[WIDTH-1:0];
                alu_carry  = wide[WIDTH];
            end
            OP_SUB: begin
                wide       = {1'b0, opa_reg} - {1'b0, opb_reg};
                alu_result = wide[WIDTH-1:0];
                alu_carry  = wide[WIDTH];
            end
            OP_AND: alu_result = opa_reg & opb_reg;
            OP_OR:  alu_result = opa_reg | opb_reg;
            OP_XOR: alu_result = opa_reg ^ opb_reg;
            OP_SHL: begin
                alu_result = {opa_reg[WIDTH-2:0], 1'b0};
                alu_carry  = opa_reg[WIDTH-1];
            end
            OP_SHR: begin
                alu_result = {1'b0, opa_reg[WIDTH-1:1]};
                alu_carry  = opa_reg[0];
            end
            OP_LDI: alu_result = imm_reg;
            default: ;
        endcase
    end

    // Select between the ALU and the multiplier for the EXEC exit edge.
    always_comb begin
        exec_done   = (op_reg == OP_MUL) ? mul_done : 1'b1;
        exec_result = (op_reg == OP_MUL) ? mul_product : alu_result;
        exec_carry  = (op_reg == OP_MUL) ? 1'b0 : alu_carry;
    end

    // Datapath: latch the instruction, capture operands, register result and flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_reg     <= '0;
            src_a_reg  <= '0;
            src_b_reg  <= '0;
            dst_reg    <= '0;
            imm_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
            flag_z_reg <= 1'b0;
            flag_n_reg <= 1'b0;
            flag_c_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && instr_valid) begin
                op_reg    <= op;
                src_a_reg <= src_a;
                src_b_reg <= src_b;
                dst_reg   <= dst;
                imm_reg   <= imm;
            end
            if (state_reg == ST_READ) begin
                opa_reg <= rf_a;
                opb_reg <= rf_b;
            end
            if (state_reg == ST_EXEC && exec_done && op_is_legal(op_reg)) begin
                result_reg <= exec_result;
                flag_z_reg <= (exec_result == '0);
                flag_n_reg <= exec_result[WIDTH-1];
                flag_c_reg <= exec_carry;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench: alu_exec_unit looped to a behavioural 8x16 register file, checked
// against an arithmetic reference model of the instruction set.
module tb_alu_exec_unit;

    localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_SHL = 4'd5, T_SHR = 4'd6;
    localparam logic [3:0] T_MUL = 4'd7, T_LDI = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  op = '0;
    logic [2:0]  src_a = '0, src_b = '0, dst = '0;
    logic [15:0] imm = '0;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] rf_a, rf_b, d_in;
    logic        wr, flag_z, flag_n, flag_c;

    logic [15:0] rf [8] = '{default: 16'h0};
    logic [15:0] ref_rf [8] = '{default: 16'h0};
    logic        ref_z = 1'b0, ref_n = 1'b0, ref_c = 1'b0;
    int          cyc = 0;
    int          tests = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file the unit is looped to: combinational read, write on edge.
    always @(posedge clk) if (wr) rf[wr_addr] <= d_in;
    assign rf_a = rf[rd_addr_a];
    assign rf_b = rf[rd_addr_b];

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .dst(dst), .imm(imm),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rf_a(rf_a), .rf_b(rf_b),
        .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
    );

    // Reference model: instruction semantics in plain unsigned arithmetic.
    task automatic model_apply(input logic [3:0] o, input logic [2:0] sa, input logic [2:0] sb,
                               input logic [2:0] d, input logic [15:0] im,
                               output bit writes, output logic [15:0] res);
        int unsigned a, b, full;
        a = ref_rf[sa];
        b = ref_rf[sb];
        writes = 1'b1;
        res = '0;
        case (o)
            4'd0: begin full = a + b; res = 16'(full); ref_c = (full > 32'hFFFF); end
            4'd1: begin res = 16'(a - b); ref_c = (a < b); end
            4'd2: begin res = 16'(a & b); ref_c = 1'b0; end
            4'd3: begin res = 16'(a | b); ref_c = 1'b0; end
            4'd4: begin res = 16'(a ^ b); ref_c = 1'b0; end
            4'd5: begin res = 16'(a * 2); ref_c = (a >= 32768); end
            4'd6: begin res = 16'(a / 2); ref_c = (a % 2 == 1); end
            4'd7: begin res = 16'(a * b); ref_c = 1'b0; end
            4'd8: begin res = im; ref_c = 1'b0; end
            default: writes = 1'b0;
        endcase
        if (writes) begin
            ref_z = (res == 16'h0);
            ref_n = (res >= 16'h8000);
            ref_rf[d] = res;
        end
    endtask

    // Issue one instruction and observe it until instr_ready returns.
    // rdy_cyc: cycle (1 = first cycle after handshake) in which ready is high again.
    task automatic run_instr(input logic [3:0] o, input logic [2:0] sa, input logic [2:0] sb,
                             input logic [2:0] d, input logic [15:0] im,
                             output int rdy_cyc, output int wr_cnt, output int wr_cyc,
                             output logic [2:0] wa, output logic [15:0] wd, output int hs_cyc);
        int guard;
        rdy_cyc = 0; wr_cnt = 0; wr_cyc = 0; wa = '0; wd = '0; hs_cyc = 0;
        guard = 0;
        while (!instr_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!instr_ready) begin
            tests++; failures++;
            $display("[TB] FAIL ready_wait: instr_ready=%b, required 1 within 50 cycles", instr_ready);
            return;
        end
        instr_valid = 1'b1; op = o; src_a = sa; src_b = sb; dst = d; imm = im;
        @(posedge clk); #1;
        hs_cyc = cyc;
        instr_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (wr) begin
                wr_cnt++; wr_cyc = n; wa = wr_addr; wd = d_in;
            end
            if (instr_ready) begin
                rdy_cyc = n;
                break;
            end
            @(posedge clk); #1;
        end
        if (rdy_cyc == 0) begin
            tests++; failures++;
            $display("[TB] FAIL instr_timeout: op=%0d never returned ready within 40 cycles", o);
        end
        $display("[TB] op=%0d a=r%0d b=r%0d dst=r%0d imm=%h wr_cnt=%0d d_in=%h ready_cycle=%0d",
                 o, sa, sb, d, im, wr_cnt, wd, rdy_cyc);
    endtask

    task automatic ldi(input logic [2:0] d, input logic [15:0] v);
        int rc, wc, wy, hs; logic [2:0] wa; logic [15:0] wd; bit w; logic [15:0] r;
        run_instr(T_LDI, 3'd0, 3'd0, d, v, rc, wc, wy, wa, wd, hs);
        model_apply(T_LDI, 3'd0, 3'd0, d, v, w, r);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr_valid = 1'b1; op = T_LDI; src_a = 3'd5; src_b = 3'd6; dst = 3'd1; imm = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (instr_ready !== 1'b0 || wr !== 1'b0 || wr_addr !== 3'd0 || d_in !== 16'h0 ||
                rd_addr_a !== 3'd0 || rd_addr_b !== 3'd0 || {flag_z, flag_n, flag_c} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL reset_values: ready=%b wr=%b wa=%0d d_in=%h ra=%0d rb=%0d znc=%b%b%b, required all 0",
                         instr_ready, wr, wr_addr, d_in, rd_addr_a, rd_addr_b, flag_z, flag_n, flag_c);
            end
        end
        instr_valid = 1'b0;
        reset = 1'b1;
        #1;
        tests++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready: instr_ready=%b, required 1", instr_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (rd_addr_a !== 3'd0 || instr_ready !== 1'b1 || rf[1] !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_no_accept: rd_addr_a=%0d ready=%b r1=%h, required 0 1 0000",
                     rd_addr_a, instr_ready, rf[1]);
        end
    endtask

    task automatic test_add();
        int rc, wc, wy, hs1, hs2; logic [2:0] wa; logic [15:0] wd; bit w; logic [15:0] r;
        ldi(3'd1, 16'h7FFF);
        run_instr(T_LDI, 3'd0, 3'd0, 3'd2, 16'h0001, rc, wc, wy, wa, wd, hs1);
        model_apply(T_LDI, 3'd0, 3'd0, 3'd2, 16'h0001, w, r);
        run_instr(T_ADD, 3'd1, 3'd2, 3'd3, 16'h0, rc, wc, wy, wa, wd, hs2);
        model_apply(T_ADD, 3'd1, 3'd2, 3'd3, 16'h0, w, r);
        tests++;
        if (rf[3] !== 16'h8000) begin
            failures++; $display("[TB] FAIL add_result: r3=%h, required 8000", rf[3]);
        end
        tests++;
        if ({flag_z, flag_n, flag_c} !== 3'b010) begin
            failures++; $display("[TB] FAIL add_flags: znc=%b%b%b, required 010", flag_z, flag_n, flag_c);
        end
        tests++;
        if (wc !== 1 || wy !== 3 || rc !== 4) begin
            failures++;
            $display("[TB] FAIL add_timing: wr_cnt=%0d wr_cycle=%0d ready_cycle=%0d, required 1 3 4", wc, wy, rc);
        end
        tests++;
        if (hs2 - hs1 !== 4) begin
            failures++; $display("[TB] FAIL add_spacing: %0d cycles, required 4", hs2 - hs1);
        end
    endtask

    task automatic test_sub();
        int rc, wc, wy, hs; logic [2:0] wa; logic [15:0] wd; bit w; logic [15:0] r;
        ldi(3'd1, 16'h0003);
        ldi(3'd2, 16'h0005);
        run_instr(T_SUB, 3'd1, 3'd2, 3'd4, 16'h0, rc, wc, wy, wa, wd, hs);
        model_apply(T_SUB, 3'd1, 3'd2, 3'd4, 16'h0, w, r);
        tests++;
        if (rf[4] !== 16'hFFFE || {flag_z, flag_n, flag_c} !== 3'b011) begin
            failures++;
            $display("[TB] FAIL sub_borrow: r4=%h znc=%b%b%b, required FFFE 011", rf[4], flag_z, flag_n, flag_c);
        end
        run_instr(T_SUB, 3'd2, 3'd2, 3'd5, 16'h0, rc, wc, wy, wa, wd, hs);
        model_apply(T_SUB, 3'd2, 3'd2, 3'd5, 16'h0, w, r);
        tests++;
        if (rf[5] !== 16'h0000 || {flag_z, flag_n, flag_c} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL sub_zero: r5=%h znc=%b%b%b, required 0000 100", rf[5], flag_z, flag_n, flag_c);
        end
    endtask

    task automatic test_shift();
        int rc, wc, wy, hs; logic [2:0] wa; logic [15:0] wd; bit w; logic [15:0] r;
        ldi(3'd1, 16'h8001);
        run_instr(T_SHL, 3'd1, 3'd0, 3'd6, 16'h0, rc, wc, wy, wa, wd, hs);
        model_apply(T_SHL, 3'd1, 3'd0, 3'd6, 16'h0, w, r);
        tests++;
        if (rf[6] !== 16'h0002 || flag_c !== 1'b1) begin
            failures++; $display("[TB] FAIL shl1: r6=%h c=%b, required 0002 1", rf[6], flag_c);
        end
        run_instr(T_SHR, 3'd1, 3'd0, 3'd6, 16'h0, rc, wc, wy, wa, wd, hs);
        model_apply(T_SHR, 3'd1, 3'd0, 3'd6, 16'h0, w, r);
        tests++;
        if (rf[6] !== 16'h4000 || flag_c !== 1'b1) begin
            failures++; $display("[TB] FAIL shr1: r6=%h c=%b, required 4000 1", rf[6], flag_c);
        end
    endtask

    task automatic test_mul();
        int rc, wc, wy, hs; logic [2:0] wa; logic [15:0] wd; bit w; logic [15:0] r;
        ldi(3'd1, 16'h0123);
        ldi(3'd2, 16'h0045);
        run_instr(T_MUL, 3'd1, 3'd2, 3'd7, 16'h0, rc, wc, wy, wa, wd, hs);
        model_apply(T_MUL, 3'd1, 3'd2, 3'd7, 16'h0, w, r);
        tests++;
        if (rf[7] !== 16'h4E6F) begin
            failures++; $display("[TB] FAIL mul_result: r7=%h, required 4E6F", rf[7]);
        end
        tests++;
        if (rc !== 19 || wy !== 18 || wc !== 1) begin
            failures++;
            $display("[TB] FAIL mul_timing: ready_cycle=%0d wr_cycle=%0d wr_cnt=%0d, required 19 18 1", rc, wy, wc);
        end
    endtask

    task automatic test_illegal();
        int rc, wc, wy, hs; logic [2:0] wa; logic [15:0] wd; bit w; logic [15:0] r;
        logic [15:0] r3_before; logic [2:0] f_before;
        r3_before = rf[3];
        f_before = {flag_z, flag_n, flag_c};
        run_instr(4'd12, 3'd1, 3'd2, 3'd3, 16'h5A5A, rc, wc, wy, wa, wd, hs);
        model_apply(4'd12, 3'd1, 3'd2, 3'd3, 16'h5A5A, w, r);
        tests++;
        if (wc !== 0 || rc !== 3) begin
            failures++; $display("[TB] FAIL illegal_timing: wr_cnt=%0d ready_cycle=%0d, required 0 3", wc, rc);
        end
        tests++;
        if (rf[3] !== r3_before || {flag_z, flag_n, flag_c} !== f_before) begin
            failures++;
            $display("[TB] FAIL illegal_state: r3=%h znc=%b%b%b, required %h %b",
                     rf[3], flag_z, flag_n, flag_c, r3_before, f_before);
        end
    endtask

    task automatic test_reset_mid_mul();
        int wr_seen;
        ldi(3'd5, 16'h1111);
        ldi(3'd1, 16'h00FF);
        ldi(3'd2, 16'h0033);
        instr_valid = 1'b1; op = T_MUL; src_a = 3'd1; src_b = 3'd2; dst = 3'd5; imm = '0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        // cycle 1 is READ; advance to cycle 9 = EXEC cycle 8
        repeat (8) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        ref_z = 1'b0; ref_n = 1'b0; ref_c = 1'b0;
        tests++;
        if (instr_ready !== 1'b0 || wr !== 1'b0 || wr_addr !== 3'd0 || d_in !== 16'h0 ||
            rd_addr_a !== 3'd0 || rd_addr_b !== 3'd0 || {flag_z, flag_n, flag_c} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL midmul_reset_values: ready=%b wr=%b wa=%0d d_in=%h ra=%0d rb=%0d znc=%b%b%b, required all 0",
                     instr_ready, wr, wr_addr, d_in, rd_addr_a, rd_addr_b, flag_z, flag_n, flag_c);
        end
        reset = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (wr) wr_seen++;
        end
        tests++;
        if (wr_seen !== 0 || rf[5] !== 16'h1111 || instr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midmul_discard: wr_seen=%0d r5=%h ready=%b, required 0 1111 1",
                     wr_seen, rf[5], instr_ready);
        end
    endtask

    task automatic test_random();
        int rc, wc, wy, hs; logic [2:0] wa; logic [15:0] wd; bit w; logic [15:0] r;
        logic [3:0] o; logic [2:0] sa, sb, d; logic [15:0] im;
        int exp_rc; int bad;
        for (int i = 0; i < 8; i++) ldi(3'(i), 16'($urandom));
        for (int t = 0; t < 40; t++) begin
            o  = 4'($urandom_range(0, 11));
            sa = 3'($urandom_range(0, 7));
            sb = 3'($urandom_range(0, 7));
            d  = 3'($urandom_range(0, 7));
            im = 16'($urandom);
            run_instr(o, sa, sb, d, im, rc, wc, wy, wa, wd, hs);
            model_apply(o, sa, sb, d, im, w, r);
            exp_rc = !w ? 3 : ((o == T_MUL) ? 19 : 4);
            tests++;
            if (rc !== exp_rc || wc !== (w ? 1 : 0) || (w && (wa !== d || wd !== r))) begin
                failures++;
                $display("[TB] FAIL rand_txn %0d op=%0d: ready_cycle=%0d wr_cnt=%0d wa=%0d d_in=%h, required %0d %0d %0d %h",
                         t, o, rc, wc, wa, wd, exp_rc, w ? 1 : 0, d, r);
            end
            bad = 0;
            for (int k = 0; k < 8; k++) if (rf[k] !== ref_rf[k]) bad++;
            tests++;
            if (bad != 0 || {flag_z, flag_n, flag_c} !== {ref_z, ref_n, ref_c}) begin
                failures++;
                $display("[TB] FAIL rand_state %0d op=%0d: %0d regs differ, znc=%b%b%b, required znc=%b%b%b",
                         t, o, bad, flag_z, flag_n, flag_c, ref_z, ref_n, ref_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_mul();
        test_illegal();
        test_reset_mid_mul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential execute/write-back stage that sits directly downstream of the 8×16 register file and closes the loop back into its write port. It accepts one instruction at a time over a valid/ready handshake and drives the register file's two read addresses. It captures both operands, computes a 16-bit result (single-cycle ALU ops, or a 16-cycle shift-add multiply) and writes the result back through the register file's write port. It also maintains zero/negative/carry flags.

## Interface
- WIDTH, 16, data word width; fixed to the register-file word.
- ADDR_W, 3, register address width; fixed to the 8-entry register file.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset (0 sampled at a rising edge resets the block).
- instr_valid  in  1  instruction fields are valid.
- instr_ready  out  1  high only in IDLE with reset high; transfer on an edge where valid & ready.
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1 (logical), 7 MUL, 8 LDI, 9–15 illegal.
- src_a, src_b  in  3  source register addresses.
- dst  in  3  destination register address.
- imm  in  16  immediate, used by LDI only.
- rd_addr_a, rd_addr_b  out  3  to register-file read ports A/B.
- rf_a, rf_b  in  16  register-file read data A/B (combinational from rd_addr).
- wr  out  1  register-file write enable.
- wr_addr  out  3  register-file write address.
- d_in  out  16  register-file write data.
- flag_z, flag_n, flag_c  out  1  zero, negative, carry flags.

## Operation
- States: IDLE → READ → EXEC → WRITE → IDLE.
- IDLE: instr_ready=1. On handshake, latch op, src_a, src_b, dst and imm, then go to READ.
- READ: rd_addr_a/b driven from the latched sources. At the edge, capture rf_a/rf_b into operand registers and go to EXEC.
- EXEC: non-MUL ops take one cycle; the result is registered at the exit edge.
- MUL: 16 iterations of shift-add, one multiplier bit per cycle (4-bit iteration counter). Exits EXEC on the 16th edge. The result is the low 16 bits of the product.
- WRITE: wr=1, wr_addr=dst and d_in=result for exactly one cycle. The register file loads at the WRITE exit edge.
- Illegal ops: EXEC lasts 1 cycle, then go straight to IDLE. No WRITE, flags unchanged.
- Flags are updated at the EXEC→WRITE edge:
  - Z = (result==0); N = result[15].
  - C = carry-out for ADD; borrow (rf_a < rf_b unsigned) for SUB.
  - C = bit shifted out for SHL1 (a[15]) and SHR1 (a[0]).
  - C = 0 for AND/OR/XOR/MUL/LDI.
- Arithmetic is 16-bit modulo 2^16; operands are treated as unsigned.
- LDI: the result is imm; it still passes through READ and EXEC (the read data is ignored).
- src_a == src_b is legal; src == dst is legal. No hazards exist, because the next instruction is accepted only after write-back completes.
- Reset low at any edge forces IDLE from any state, including mid-MUL and during WRITE.
  - The in-flight instruction is discarded; no write occurs after that edge.
  - An instruction presented while reset is low is not accepted.

## Timing
- Reset values: state IDLE, rd_addr_a/b=0, wr=0, wr_addr=0, d_in=0, flag_z/n/c=0, instr_ready=0 while reset low and 1 after release.
- Non-MUL latency: handshake at edge T0; READ in T0–T1; EXEC in T1–T2; wr high in T2–T3; register updated at T3; instr_ready high again in T3–T4.
- Throughput: one instruction per 4 cycles (non-MUL), per 19 cycles (MUL), per 3 cycles (illegal).
- wr, wr_addr and d_in are registered or decoded from registered state only, so they are glitch-free.

## Structure
- Shared package holds: opcode constants, state encoding, WIDTH/ADDR_W, and the MUL iteration count (16).
- One sub-module, mul16_seq: start/done handshake, 16-cycle shift-add multiplier, synchronous active-low reset.
- Bench: alu_exec_unit looped to the existing register file; registers are preloaded via LDI.

## Test plan
- Reset, then LDI r1=0x7FFF and LDI r2=0x0001, then ADD r3=r1+r2 → r3=0x8000, N=1, Z=0, C=0; wr pulses exactly 1 cycle; 4-cycle spacing between handshakes.
- LDI r1=0x0003, r2=0x0005, SUB r4=r1-r2 → r4=0xFFFE, C=1, N=1. Then SUB r5=r2-r2 → r5=0x0000, Z=1, C=0.
- LDI r1=0x8001: SHL1 r6=r1 → 0x0002, C=1. SHR1 r6=r1 → 0x4000, C=1.
- LDI r1=0x0123, r2=0x0045, MUL r7=r1*r2 → r7=0x4E6F. instr_ready is low for 18 cycles after the handshake; wr is asserted in cycle 18.
- Issue op=12 with dst=r3 → no wr pulse, r3 and flags unchanged, instr_ready back after 3 cycles.
- Start MUL, pull reset low at EXEC cycle 8 → next cycle IDLE, all outputs at reset values, wr never asserted, dst register unchanged.
